// File: rtl/rf_pkg.sv
// Shared register-file constants and the writeback request bundle used by the
// write-port arbiter.
package rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = 5'd0;

  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_age_ctr.sv
// Saturating aging counter: counts consecutive refusals of port A and flags
// when the count has reached max_wait, which forces A to win arbitration.
module rf_wb_age_ctr #(
  parameter int MAX_WAIT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] count,
  output logic       at_max
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 4'd0;
    end else if (clear) begin
      count <= 4'd0;
    end else if (inc && (count < MAX_CNT)) begin
      count <= count + 4'd1;
    end
  end

  assign at_max = (count == MAX_CNT);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-port controller for the 32x32 register file: arbitrates ALU (A) and
// load unit (B) writebacks, B first with aging to protect A. Build macro
// RF_WB_BYPASS_EN adds same-cycle read-after-write forwarding flags.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int MAX_WAIT = 3,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_valid,
  input  logic [RF_ADDR_W-1:0] a_rd,
  input  logic [RF_DATA_W-1:0] a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [RF_ADDR_W-1:0] b_rd,
  input  logic [RF_DATA_W-1:0] b_data,
  output logic                 b_ready,
  input  logic                 stall,
  output logic                 regWrite,
  output logic [RF_ADDR_W-1:0] rd,
  output logic [RF_DATA_W-1:0] writeData,
  output logic [CNT_W-1:0]     wb_count,
`ifdef RF_WB_BYPASS_EN
  input  logic [RF_ADDR_W-1:0] rs_q,
  input  logic [RF_ADDR_W-1:0] rt_q,
  output logic                 fwd_rs,
  output logic                 fwd_rt,
`endif
  output logic                 a_starved
);

  // Handshake: a write transfers on a port in the cycle valid && ready are
  // both high; the requester holds valid/rd/data stable until it sees ready.
  wb_req_t    a_req, b_req, win;
  logic [3:0] wait_cnt;
  logic       at_max;

  assign a_req = '{valid: a_valid, rd: a_rd, data: a_data};
  assign b_req = '{valid: b_valid, rd: b_rd, data: b_data};

  rf_wb_age_ctr #(.MAX_WAIT(MAX_WAIT)) u_age (
    .clk    (clk),
    .reset  (reset),
    .clear  (!a_valid || a_ready),
    .inc    (a_valid && !a_ready),
    .count  (wait_cnt),
    .at_max (at_max)
  );

  // Reset also blocks grants so a request seen during reset is not consumed.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    win     = b_req;
    if (!reset && !stall) begin
      if (a_req.valid && (at_max || !b_req.valid)) begin
        a_ready = 1'b1;
        win     = a_req;
      end else if (b_req.valid) begin
        b_ready = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regWrite  <= 1'b0;
      rd        <= RF_ZERO_REG;
      writeData <= '0;
      wb_count  <= '0;
    end else if (a_ready || b_ready) begin
      rd        <= win.rd;
      writeData <= win.data;
      regWrite  <= (win.rd != RF_ZERO_REG);
      if (win.rd != RF_ZERO_REG) begin
        wb_count <= wb_count + CNT_W'(1);
      end
    end else begin
      regWrite <= 1'b0;
    end
  end

  assign a_starved = at_max;

`ifdef RF_WB_BYPASS_EN
  assign fwd_rs = regWrite && (rd != RF_ZERO_REG) && (rd == rs_q);
  assign fwd_rt = regWrite && (rd != RF_ZERO_REG) && (rd == rt_q);
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, win.valid};

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter (MAX_WAIT=3, CNT_W=4): directed vectors with literal
// checks plus a rule-level model compared on every falling edge.
module tb_rf_wb_arbiter;
  localparam int MW = 3;
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0, stall = 1'b0;
  logic [4:0]  a_rd = '0, b_rd = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready, regWrite, a_starved;
  logic [4:0]  rd;
  logic [31:0] writeData;
  logic [CW-1:0] wb_count;
`ifdef RF_WB_BYPASS_EN
  logic [4:0]  rs_q = '0, rt_q = '0;
  logic        fwd_rs, fwd_rt;
`endif

  int n_run  = 0;
  int n_fail = 0;

  rf_wb_arbiter #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .stall(stall), .regWrite(regWrite), .rd(rd), .writeData(writeData),
    .wb_count(wb_count),
`ifdef RF_WB_BYPASS_EN
    .rs_q(rs_q), .rt_q(rt_q), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
`endif
    .a_starved(a_starved)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard model ----------------
  logic [36:0] exp_q[$];
  int          m_wait = 0;
  int          m_cnt  = 0;
  logic [4:0]  m_rd   = '0;
  logic [31:0] m_data = '0;
  logic        ga, gb;
  logic [36:0] e;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("m_regwrite", 64'(regWrite), 64'd1);
    end else begin
      chk("m_regwrite", 64'(regWrite), 64'd0);
    end
    chk("m_rd", 64'(rd), 64'(m_rd));
    chk("m_wdata", 64'(writeData), 64'(m_data));
    chk("m_count", 64'(wb_count), 64'(m_cnt));
    chk("m_starved", 64'(a_starved), 64'(m_wait == MW));

    ga = 1'b0;
    gb = 1'b0;
    if (!reset && !stall) begin
      if (a_valid && (m_wait == MW || !b_valid)) ga = 1'b1;
      else if (b_valid) gb = 1'b1;
    end
    chk("m_a_ready", 64'(a_ready), 64'(ga));
    chk("m_b_ready", 64'(b_ready), 64'(gb));

    if (reset) begin
      exp_q.delete();
      m_wait = 0;
      m_cnt  = 0;
      m_rd   = '0;
      m_data = '0;
    end else begin
      if (ga || gb) begin
        m_rd   = ga ? a_rd : b_rd;
        m_data = ga ? a_data : b_data;
        if (m_rd != 5'd0) begin
          exp_q.push_back({m_rd, m_data});
          m_cnt = (m_cnt + 1) % (1 << CW);
        end
      end
      if (!a_valid || ga) m_wait = 0;
      else if (m_wait < MW) m_wait = m_wait + 1;
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    // 1: reset held two cycles with both requesters valid
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h0000_00A3;
    b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h0000_00B4;
    step(); step();
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_b_ready", 64'(b_ready), 64'd0);
    chk("rst_regwrite", 64'(regWrite), 64'd0);
    chk("rst_count", 64'(wb_count), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_b_first", 64'(b_ready), 64'd1);
    chk("post_rst_a_wait", 64'(a_ready), 64'd0);
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("b_write_rd", 64'(rd), 64'd4);
    chk("b_write_cnt", 64'(wb_count), 64'd1);
    step();

    // 2: A alone
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEAD_BEEF;
    #1;
    chk("a_only_ready", 64'(a_ready), 64'd1);
    step();
    a_valid = 1'b0;
    chk("a_only_we", 64'(regWrite), 64'd1);
    chk("a_only_rd", 64'(rd), 64'd5);
    chk("a_only_data", 64'(writeData), 64'hDEAD_BEEF);
    chk("a_only_cnt", 64'(wb_count), 64'd2);
    step();

    // 3: both valid continuously -> B,B,B,A,B,B,B,A
    a_valid = 1'b1; a_rd = 5'd10; a_data = 32'h1111_0000;
    b_valid = 1'b1; b_rd = 5'd11; b_data = 32'h2222_0000;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("age_a_ready", 64'(a_ready), 64'((i % 4) == 3));
      chk("age_b_ready", 64'(b_ready), 64'((i % 4) != 3));
      chk("age_starved", 64'(a_starved), 64'((i % 4) == 3));
      step();
      a_data = a_data + 32'd1;
      b_data = b_data + 32'd1;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    chk("age_last_rd", 64'(rd), 64'd10);
    chk("age_cnt", 64'(wb_count), 64'd10);
    step();

    // 4: B writes r0 -> accepted, no write, count unchanged
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h0000_1234;
    #1;
    chk("r0_ready", 64'(b_ready), 64'd1);
    step();
    b_valid = 1'b0;
    chk("r0_we", 64'(regWrite), 64'd0);
    chk("r0_cnt", 64'(wb_count), 64'd10);
    chk("r0_data", 64'(writeData), 64'h1234);
    step();

    // 5: stall five cycles with both valid, then A wins
    stall = 1'b1;
    a_valid = 1'b1; a_rd = 5'd20; a_data = 32'hA5A5_0020;
    b_valid = 1'b1; b_rd = 5'd21; b_data = 32'h5A5A_0021;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_a_ready", 64'(a_ready), 64'd0);
      chk("stall_b_ready", 64'(b_ready), 64'd0);
      chk("stall_starved", 64'(a_starved), 64'(i >= 3));
      step();
      chk("stall_we", 64'(regWrite), 64'd0);
    end
    stall = 1'b0;
    #1;
    chk("unstall_a_wins", 64'(a_ready), 64'd1);
    step();
    a_valid = 1'b0;
    chk("unstall_rd", 64'(rd), 64'd20);
    chk("unstall_cnt", 64'(wb_count), 64'd11);
    // B keeps requesting; same rd as the next A request to order the writes
    b_rd = 5'd9; b_data = 32'h0000_0B09;
    step();
    a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h0000_0A09;
    step();
    b_valid = 1'b0;
    step();
    a_valid = 1'b0;
    chk("same_rd_last", 64'(writeData), 64'h0000_0A09);
    step();

    // 6: counter wrap with CNT_W=4 after 17 writes
    reset = 1'b1;
    step();
    reset = 1'b0;
    a_valid = 1'b1; a_rd = 5'd7;
    for (int i = 0; i < 17; i++) begin
      a_data = 32'(i);
      step();
    end
    a_valid = 1'b0;
    #1;
    chk("wrap_cnt", 64'(wb_count), 64'd1);
    chk("wrap_model_cnt", 64'(m_cnt), 64'd1);
    chk("wrap_data", 64'(writeData), 64'd16);
`ifdef RF_WB_BYPASS_EN
    rs_q = 5'd7; rt_q = 5'd8;
    #1;
    chk("fwd_rs_hit", 64'(fwd_rs), 64'd1);
    chk("fwd_rt_miss", 64'(fwd_rt), 64'd0);
    step();
    chk("fwd_rs_idle", 64'(fwd_rs), 64'd0);
`endif
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
